// File: rtl/tx_string_arbiter.sv
// -----------------------------------------------------------------------------
// tx_string_arbiter
//
// Shares one string-transmit engine between NUM_REQ requesters. Each requester
// posts a one-cycle request pulse together with the start address of its
// string. The request is latched as "pending" and the engine is granted
// round-robin. For the winner the arbiter presents the start address, pulses
// the start strobe, waits for the engine's done strobe and then returns a
// one-cycle done pulse to that requester.
//
// Engine handshake (strobe protocol, no backpressure):
//   str_ready_o is high for exactly one cycle per job (the START cycle), and
//   str_start_addr_o is stable from the grant until the next grant. The engine
//   acts on the rising edge of str_ready_o. It answers with a one-cycle
//   str_done_i pulse. str_done_i is honoured only while waiting for the
//   current job (WAIT state) and is ignored in every other state. Between two
//   strobes str_ready_o is low for at least three cycles (WAIT, DONE, IDLE),
//   so each job gives the engine a fresh rising edge.
//
// Timing, with a request arriving while idle and nothing pending:
//   cycle 0 : req_i[i] high
//   cycle 1 : pending_o[i] high
//   cycle 2 : grant_o[i], busy_o, str_ready_o high (START)
//   cycle 3+: WAIT until str_done_i
//   str_done_i in cycle k -> req_done_o[i] in cycle k+1 (DONE)
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-low reset
//   req_i            in   [NUM_REQ]            one-cycle request pulses
//   req_addr_i       in   [NUM_REQ*ADDR_WIDTH] start addresses, slice i for req_i[i]
//   req_done_o       out  [NUM_REQ]            one-cycle pulse: string i sent
//   req_drop_o       out  [NUM_REQ]            one-cycle pulse (cycle after the
//                                              request): req_i[i] ignored because
//                                              a request for i was already pending
//   pending_o        out  [NUM_REQ]            latched, not yet completed requests
//   grant_o          out  [NUM_REQ]            one-hot engine owner, 0 when idle
//   busy_o           out                       any grant active
//   str_ready_o      out                       start strobe to the engine
//   str_start_addr_o out  [ADDR_WIDTH]         start address to the engine
//   str_done_i       in                        one-cycle done strobe from the engine
//   state_dbg_o      out  [4]                  one-hot FSM state (IDLE, START,
//                                              WAIT, DONE = bit 0..3)
// -----------------------------------------------------------------------------
module tx_string_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_done_o,
    output logic [NUM_REQ-1:0]            req_drop_o,
    output logic [NUM_REQ-1:0]            pending_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          str_ready_o,
    output logic [ADDR_WIDTH-1:0]         str_start_addr_o,
    input  logic                          str_done_i,
    output logic [3:0]                    state_dbg_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_WAIT  = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH-1:0]   addr_q [NUM_REQ];
    logic [ADDR_WIDTH-1:0]   addr_d [NUM_REQ];
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   str_addr_q, str_addr_d;
    logic [NUM_REQ-1:0]      req_drop_q, req_drop_d;

    // Combinational helpers
    logic [NUM_REQ-1:0]      done_now;
    logic [IDX_W-1:0]        win_idx;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Round-robin pick: first set bit at ptr, ptr+1, ... wrapping at NUM_REQ.
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] pick;
        int               c;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (pend[IDX_W'(c)]) pick = IDX_W'(c);
        end
        return pick;
    endfunction

    // The job of idx_q completes in the DONE cycle.
    assign done_now = (state_q == S_DONE) ? onehot(idx_q) : '0;
    assign win_idx  = rr_pick(pending_q, rr_ptr_q);

    // -------------------------------------------------------------------------
    // Request capture
    // A request for an idle slot is latched. A request for a slot that is
    // already pending is dropped, except in the slot's completion cycle: there
    // the new request re-queues the slot with the new address (set wins).
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d  = pending_q;
        addr_d     = addr_q;
        req_drop_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (done_now[i]) pending_d[i] = 1'b0;
            if (req_i[i]) begin
                if (!pending_q[i] || done_now[i]) begin
                    pending_d[i] = 1'b1;
                    addr_d[i]    = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                end else begin
                    req_drop_d[i] = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration FSM, next-state and registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        str_addr_d = str_addr_q;
        case (state_q)
            S_IDLE: begin
                // Only requests already latched are considered, so the address
                // read from addr_q is always the one that belongs to the job.
                if (|pending_q) begin
                    idx_d      = win_idx;
                    grant_d    = onehot(win_idx);
                    busy_d     = 1'b1;
                    str_addr_d = addr_q[win_idx];
                    state_d    = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (str_done_i) state_d = S_DONE;
            end
            S_DONE: begin
                rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                grant_d  = '0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            pending_q  <= '0;
            addr_q     <= '{default: '0};
            grant_q    <= '0;
            busy_q     <= 1'b0;
            str_addr_q <= '0;
            req_drop_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            str_addr_q <= str_addr_d;
            req_drop_q <= req_drop_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_done_o       = done_now;
    assign req_drop_o       = req_drop_q;
    assign pending_o        = pending_q;
    assign grant_o          = grant_q;
    assign busy_o           = busy_q;
    assign str_ready_o      = (state_q == S_START);
    assign str_start_addr_o = str_addr_q;
    assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_tx_string_arbiter.sv
module tb_tx_string_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic            str_done;
  logic [N-1:0]    req_done, req_drop, pending, grant;
  logic            busy, str_ready;
  logic [AW-1:0]   str_start_addr;
  logic [3:0]      state_dbg;

  always #5 clock = ~clock;

  tx_string_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_i            (req),
    .req_addr_i       (req_addr),
    .req_done_o       (req_done),
    .req_drop_o       (req_drop),
    .pending_o        (pending),
    .grant_o          (grant),
    .busy_o           (busy),
    .str_ready_o      (str_ready),
    .str_start_addr_o (str_start_addr),
    .str_done_i       (str_done),
    .state_dbg_o      (state_dbg)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // one edge, then sample 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic            sdone;
    logic [N-1:0]    grant;
    logic            busy;
    logic            rdy;
    logic [AW-1:0]   saddr;
    logic [N-1:0]    pend;
    logic [N-1:0]    done;
    logic [N-1:0]    drop;
  } vec_t;

  vec_t tbl[18];

  // ---------------------------------------------------------------------------
  // Reference model: pending set, per-slot address, rotating pointer, and the
  // current job described by its owner and its age in cycles since the grant.
  // ---------------------------------------------------------------------------
  bit            m_pend[N];
  logic [AW-1:0] m_addr[N];
  int            m_rr, m_owner, m_age, m_grants;
  bit            m_fin;
  logic [N-1:0]  m_drop;
  logic [AW-1:0] m_saddr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_addr[i] = '0;
    end
    m_rr = 0; m_owner = -1; m_age = 0; m_fin = 0;
    m_drop = '0; m_saddr = '0; m_grants = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic sd);
    bit            old_pend[N];
    logic [AW-1:0] old_addr[N];
    int            fin_owner;
    old_pend  = m_pend;
    old_addr  = m_addr;
    fin_owner = m_fin ? m_owner : -1;
    m_drop    = '0;
    for (int i = 0; i < N; i++) begin
      if (i == fin_owner) m_pend[i] = 0;
      if (r[i]) begin
        if (!old_pend[i] || i == fin_owner) begin
          m_pend[i] = 1;
          m_addr[i] = a[i*AW +: AW];
        end else begin
          m_drop[i] = 1'b1;
        end
      end
    end
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_rr + k) % N;
        if (old_pend[c]) begin
          m_owner = c; m_age = 0; m_fin = 0;
          m_saddr = old_addr[c];
          m_grants++;
          break;
        end
      end
    end else if (m_fin) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
      m_fin   = 0;
    end else begin
      // the done strobe counts only once the start strobe has been given
      if (m_age >= 1 && sd) m_fin = 1;
      m_age++;
    end
  endtask

  function automatic logic [63:0] model_outputs();
    logic [N-1:0] g, p, d;
    logic         b, rd;
    g = '0; d = '0; p = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    if (m_fin) d[m_owner] = 1'b1;
    for (int i = 0; i < N; i++) p[i] = m_pend[i];
    b  = (m_owner >= 0);
    rd = (m_owner >= 0) && (m_age == 0) && !m_fin;
    return 64'({g, b, rd, m_saddr, p, d, m_drop});
  endfunction

  function automatic logic [63:0] dut_outputs();
    return 64'({grant, busy, str_ready, str_start_addr, pending, req_done, req_drop});
  endfunction

  // ---------------------------------------------------------------------------
  // Directed sequence helpers
  // ---------------------------------------------------------------------------
  task automatic serve(input string tag, input int idx, input logic [AW-1:0] exp_addr);
    int n = 0;
    while (!str_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready_within_bound"}, 64'(n < 20), 64'd1);
    check({tag, "_grant"}, 64'(grant), 64'(1 << idx));
    check({tag, "_addr"}, 64'(str_start_addr), 64'(exp_addr));
    step();
    str_done = 1'b1;
    step();
    str_done = 1'b0;
    check({tag, "_req_done"}, 64'(req_done), 64'(1 << idx));
  endtask

  // ---------------------------------------------------------------------------
  // Main
  // ---------------------------------------------------------------------------
  initial begin
    int            rises;
    logic          prev_rdy;
    logic [N-1:0]  seen_done;
    int            n;

    tbl[0]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0100, 32'hAA40_BBCC, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0100, 1'b1, 1'b1, 8'h40, 4'b0100, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0100, 1'b1, 1'b0, 8'h40, 4'b0100, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0010, 32'hDDEE_11FF, 1'b0, 4'b0100, 1'b1, 1'b0, 8'h40, 4'b0110, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0010, 32'h5566_2277, 1'b1, 4'b0100, 1'b1, 1'b0, 8'h40, 4'b0110, 4'b0100, 4'b0010};
    tbl[6]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h40, 4'b0010, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h11, 4'b0010, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h11, 4'b0010, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h11, 4'b0010, 4'b0010, 4'b0000};
    tbl[10] = '{4'b0010, 32'h9988_3377, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h11, 4'b0010, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 1'b1, 1'b1, 8'h33, 4'b0010, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h33, 4'b0010, 4'b0000, 4'b0000};
    tbl[13] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 1'b1, 1'b0, 8'h33, 4'b0010, 4'b0000, 4'b0000};
    tbl[14] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h33, 4'b0010, 4'b0010, 4'b0000};
    tbl[15] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h33, 4'b0000, 4'b0000, 4'b0000};
    tbl[16] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h33, 4'b0000, 4'b0000, 4'b0000};
    tbl[17] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h33, 4'b0000, 4'b0000, 4'b0000};

    // reset
    reset = 1'b0; req = '0; req_addr = '0; str_done = 1'b0;
    repeat (3) step();
    check("reset_outputs", dut_outputs(), 64'd0);
    reset = 1'b1;

    // table: single job, drop keeps old address, set wins in DONE,
    // done ignored in START and IDLE
    for (int k = 0; k < 18; k++) begin
      req = tbl[k].req; req_addr = tbl[k].addr; str_done = tbl[k].sdone;
      step();
      check($sformatf("tbl%0d_grant", k),   64'(grant),          64'(tbl[k].grant));
      check($sformatf("tbl%0d_busy", k),    64'(busy),           64'(tbl[k].busy));
      check($sformatf("tbl%0d_ready", k),   64'(str_ready),      64'(tbl[k].rdy));
      check($sformatf("tbl%0d_saddr", k),   64'(str_start_addr), 64'(tbl[k].saddr));
      check($sformatf("tbl%0d_pending", k), 64'(pending),        64'(tbl[k].pend));
      check($sformatf("tbl%0d_done", k),    64'(req_done),       64'(tbl[k].done));
      check($sformatf("tbl%0d_drop", k),    64'(req_drop),       64'(tbl[k].drop));
    end
    req = '0; req_addr = '0; str_done = 1'b0;

    // round-robin order: 0,1,3 from a fresh reset, then 0 before 3
    reset = 1'b0; step(); reset = 1'b1;
    req = 4'b1011; req_addr = 32'hA377_A1A0;
    step();
    req = '0; req_addr = '0;
    serve("rr_a0", 0, 8'hA0);
    serve("rr_a1", 1, 8'hA1);
    serve("rr_a3", 3, 8'hA3);
    step();
    req = 4'b1001; req_addr = 32'hB366_55B0;
    step();
    req = '0; req_addr = '0;
    serve("rr_b0", 0, 8'hB0);
    serve("rr_b3", 3, 8'hB3);
    step();
    check("rr_idle_after", 64'({busy, pending}), 64'd0);

    // reset in WAIT aborts without a done pulse
    req = 4'b0001; req_addr = 32'h0000_005A;
    step();
    req = '0; req_addr = '0;
    n = 0;
    while (!str_ready && n < 20) begin step(); n++; end
    check("abort_ready_within_bound", 64'(n < 20), 64'd1);
    step();
    check("abort_in_wait", 64'({busy, str_ready, str_start_addr}), 64'({1'b1, 1'b0, 8'h5A}));
    #2 reset = 1'b0;
    #1 check("abort_async_clear", dut_outputs(), 64'd0);
    step();
    reset = 1'b1;
    str_done = 1'b1;
    step();
    str_done = 1'b0;
    seen_done = req_done;
    for (int k = 0; k < 4; k++) begin
      step();
      seen_done |= req_done;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_idle", 64'({busy, pending}), 64'd0);

    // randomized traffic against the model
    reset = 1'b0; step(); reset = 1'b1;
    model_reset();
    rises = 0; prev_rdy = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 4) == 0);
      req_addr = $urandom;
      str_done = ($urandom_range(0, 2) == 0);
      model_step(req, req_addr, str_done);
      step();
      check($sformatf("rand_cyc%0d", cyc), dut_outputs(), model_outputs());
      if (str_ready && !prev_rdy) rises++;
      prev_rdy = str_ready;
    end
    req = '0; str_done = 1'b0;
    check("ready_edges_vs_grants", 64'(rises), 64'(m_grants));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
